// File: rtl/oq_sram_arbiter_if.sv
// Output-queue SRAM port bundle: one write requester and one read requester.
// Requests are level req/ack handshakes; read data returns later qualified by rd_0_vld.
// master = requester side (output_queues), slave = the SRAM arbiter.
interface oq_sram_arbiter_if #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int SRAM_ADDR_WIDTH = 13
);
  localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;

  logic                       wr_0_req;
  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr;
  logic [WORD_WIDTH-1:0]      wr_0_data;
  logic                       wr_0_ack;
  logic                       rd_0_req;
  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr;
  logic                       rd_0_ack;
  logic [WORD_WIDTH-1:0]      rd_0_data;
  logic                       rd_0_vld;

  modport master (
    output wr_0_req, wr_0_addr, wr_0_data, rd_0_req, rd_0_addr,
    input  wr_0_ack, rd_0_ack, rd_0_data, rd_0_vld
  );

  modport slave (
    input  wr_0_req, wr_0_addr, wr_0_data, rd_0_req, rd_0_addr,
    output wr_0_ack, rd_0_ack, rd_0_data, rd_0_vld
  );
endinterface

// File: rtl/oq_sram_arbiter.sv
// Single-port SRAM responder arbitrating one writer and one reader with bounded bursts and turnaround.
// Latency: acks are combinational in the owning state; read data returns RD_LATENCY cycles after rd_0_ack.
// Backpressure: a requester holds req/addr/data until acked; the waiting side gets the bus after MAX_BURST grants.
module oq_sram_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int RD_LATENCY      = 2,
  parameter int MAX_BURST       = 8,
  parameter int TURN_CYCLES     = 1
) (
  input logic               clk,
  input logic               reset,
  oq_sram_arbiter_if.slave  sram
);
  localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;
  localparam int DEPTH      = 1 << SRAM_ADDR_WIDTH;
  localparam int BW         = $clog2(MAX_BURST + 1);
  localparam int TW         = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN, TURN} state_t;

  state_t          state, state_nxt;
  logic            bus_dir, dir_nxt;
  logic [BW-1:0]   burst_cnt, burst_nxt;
  logic [TW-1:0]   turn_cnt, turn_nxt;

  logic            wr_req, rd_req;
  logic            wr_ack, rd_ack;
  logic            own_req, oth_req;
  logic            pick_wr, pick_rd, pick_dir;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [RD_LATENCY-1:0] p_vld;
  logic [WORD_WIDTH-1:0] p_dat [RD_LATENCY];

  assign wr_req = sram.wr_0_req;
  assign rd_req = sram.rd_0_req;

  // On a tie the bus goes to the direction it is not currently facing.
  assign pick_wr  = wr_req && (!rd_req || (bus_dir == DIR_RD));
  assign pick_rd  = rd_req && (!wr_req || (bus_dir == DIR_WR));
  assign pick_dir = pick_wr ? DIR_WR : DIR_RD;

  // Arbitration state, bus direction and burst/turnaround counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus_dir   <= DIR_RD;
      burst_cnt <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      bus_dir   <= dir_nxt;
      burst_cnt <= burst_nxt;
      turn_cnt  <= turn_nxt;
    end
  end

  // Next-state and ack decode; acks only ever come from the owning state.
  always_comb begin
    state_nxt = state;
    dir_nxt   = bus_dir;
    burst_nxt = burst_cnt;
    turn_nxt  = turn_cnt;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    own_req   = 1'b0;
    oth_req   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_wr || pick_rd) begin
          if (pick_dir == bus_dir) begin
            state_nxt = pick_wr ? WR_OWN : RD_OWN;
            burst_nxt = '0;
          end else begin
            state_nxt = TURN;
            turn_nxt  = '0;
          end
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          dir_nxt   = ~bus_dir;
          burst_nxt = '0;
          turn_nxt  = '0;
          state_nxt = (bus_dir == DIR_RD) ? WR_OWN : RD_OWN;
        end else begin
          turn_nxt = turn_cnt + TW'(1);
        end
      end
      WR_OWN, RD_OWN: begin
        own_req = (state == WR_OWN) ? wr_req : rd_req;
        oth_req = (state == WR_OWN) ? rd_req : wr_req;
        wr_ack  = (state == WR_OWN) && wr_req;
        rd_ack  = (state == RD_OWN) && rd_req;
        if (own_req && (burst_cnt != BURST_MAX)) begin
          burst_nxt = burst_cnt + BW'(1);
        end
        // Saturated counts still hand over, so a long solo burst cannot starve a late arrival.
        if (oth_req && (!own_req || (burst_cnt >= BURST_LAST))) begin
          state_nxt = TURN;
          turn_nxt  = '0;
        end else if (!own_req && !oth_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory write at the edge closing the write-ack cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ack) begin
      mem[sram.wr_0_addr] <= sram.wr_0_data;
    end
  end

  // Read pipeline: array read in the ack cycle, then delayed; each stage only
  // loads on a valid word so the output register holds its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        p_dat[i] <= '0;
      end
    end else begin
      p_vld[0] <= rd_ack;
      if (rd_ack) begin
        p_dat[0] <= mem[sram.rd_0_addr];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        p_vld[i] <= p_vld[i-1];
        if (p_vld[i-1]) begin
          p_dat[i] <= p_dat[i-1];
        end
      end
    end
  end

  assign sram.wr_0_ack  = wr_ack;
  assign sram.rd_0_ack  = rd_ack;
  assign sram.rd_0_vld  = p_vld[RD_LATENCY-1];
  assign sram.rd_0_data = p_dat[RD_LATENCY-1];
endmodule

// File: tb/tb_oq_sram_arbiter.sv
// Bench for oq_sram_arbiter: a cycle table for write/read/reset basics, then
// request streams with a memory model for bursts, arbitration pattern and wrap.
module tb_oq_sram_arbiter;
  localparam int RD_LAT = 2;
  localparam int AW     = 13;
  localparam int WW     = 72;
  localparam int NV     = 15;

  localparam logic [WW-1:0] D1 = 72'h00_DEADBEEF_CAFEF00D;
  localparam logic [WW-1:0] DA = 72'h5A_0123456789ABCDEF;
  localparam logic [WW-1:0] DB = 72'hA5_FEDCBA9876543210;
  localparam logic [AW-1:0] A10 = 13'h0010;

  logic clk;
  logic reset;

  oq_sram_arbiter_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .SRAM_ADDR_WIDTH(AW)) bus ();

  oq_sram_arbiter #(
    .DATA_WIDTH(64), .CTRL_WIDTH(8), .SRAM_ADDR_WIDTH(AW),
    .RD_LATENCY(RD_LAT), .MAX_BURST(4), .TURN_CYCLES(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sram  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rst;
    logic          wr;
    logic [AW-1:0] wa;
    logic [WW-1:0] wd;
    logic          rd;
    logic [AW-1:0] ra;
    logic          e_wack;
    logic          e_rack;
    logic          e_vld;
    logic [WW-1:0] e_dat;
  } vec_t;

  vec_t vt [NV];

  int n_cmp;
  int n_bad;

  logic [WW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] wq_a [$];
  logic [WW-1:0] wq_d [$];
  logic [AW-1:0] rq_a [$];
  logic [WW-1:0] exp_d [$];
  int            exp_c [$];
  logic [WW-1:0] got_d [$];
  bit            wr_tr [$];
  bit            rd_tr [$];

  function automatic vec_t mkv(logic rst, logic wr, logic [AW-1:0] wa, logic [WW-1:0] wd,
                               logic rd, logic [AW-1:0] ra, logic e_wack, logic e_rack,
                               logic e_vld, logic [WW-1:0] e_dat);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
    v.e_wack = e_wack; v.e_rack = e_rack; v.e_vld = e_vld; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, why);
  endtask

  task automatic idle_bus(input int n);
    bus.wr_0_req = 1'b0;
    bus.rd_0_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents queued writes/reads one per cycle, logs acks, checks returned data and latency.
  task automatic run_streams(input string tag, input int max_cyc);
    int   cyc;
    int   both;
    logic wa;
    logic ra;
    cyc  = 0;
    both = 0;
    wr_tr.delete();
    rd_tr.delete();
    got_d.delete();
    forever begin
      bus.wr_0_req = (wq_a.size() != 0);
      if (wq_a.size() != 0) begin
        bus.wr_0_addr = wq_a[0];
        bus.wr_0_data = wq_d[0];
      end
      bus.rd_0_req = (rq_a.size() != 0);
      if (rq_a.size() != 0) bus.rd_0_addr = rq_a[0];
      @(negedge clk);
      wa = bus.wr_0_ack;
      ra = bus.rd_0_ack;
      wr_tr.push_back(wa === 1'b1);
      rd_tr.push_back(ra === 1'b1);
      if (wa === 1'b1 && ra === 1'b1) both++;
      if (bus.rd_0_vld === 1'b1) begin
        if (exp_d.size() == 0) begin
          fail({tag, " rd_vld"}, $sformatf("pulse at cycle %0d with no read outstanding", cyc));
        end else begin
          chk({tag, " rd_data"}, bus.rd_0_data, exp_d[0]);
          chk({tag, " rd_latency_cycle"}, WW'(cyc), WW'(exp_c[0]));
          got_d.push_back(bus.rd_0_data);
          void'(exp_d.pop_front());
          void'(exp_c.pop_front());
        end
      end
      if (wa === 1'b1) begin
        if (wq_a.size() == 0) fail({tag, " wr_ack"}, "ack with no write pending");
        else begin
          ref_mem[wq_a[0]] = wq_d[0];
          void'(wq_a.pop_front());
          void'(wq_d.pop_front());
        end
      end
      if (ra === 1'b1) begin
        if (rq_a.size() == 0) fail({tag, " rd_ack"}, "ack with no read pending");
        else begin
          exp_d.push_back(ref_mem[rq_a[0]]);
          exp_c.push_back(cyc + RD_LAT);
          void'(rq_a.pop_front());
        end
      end
      cyc++;
      if (wq_a.size() == 0 && rq_a.size() == 0 && exp_d.size() == 0) break;
      if (cyc >= max_cyc) begin
        fail({tag, " timeout"}, $sformatf("%0d writes, %0d reads, %0d returns still pending",
                                          wq_a.size(), rq_a.size(), exp_d.size()));
        wq_a.delete(); wq_d.delete(); rq_a.delete(); exp_d.delete(); exp_c.delete();
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, " both_acks_cycles"}, WW'(both), WW'(0));
    @(posedge clk);
    #1;
    idle_bus(2);
  endtask

  initial begin
    int first;
    int nack;
    int gaps;
    int nrd;
    int run;
    int best;
    int perr;
    int k;
    bit ew;
    bit er;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.wr_0_req  = 1'b0;
    bus.wr_0_addr = '0;
    bus.wr_0_data = '0;
    bus.rd_0_req  = 1'b0;
    bus.rd_0_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Write 0x10 then read it back; later a read is acked and reset lands before its data.
    //            rst   wr    wa   wd     rd    ra     wack  rack  vld   data
    vt[0]  = mkv(1'b1, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b0, '0);
    vt[1]  = mkv(1'b0, 1'b1, A10, D1,    1'b0, '0,    1'b0, 1'b0, 1'b0, '0);
    vt[2]  = mkv(1'b0, 1'b1, A10, D1,    1'b0, '0,    1'b0, 1'b0, 1'b0, '0);
    vt[3]  = mkv(1'b0, 1'b1, A10, D1,    1'b0, '0,    1'b1, 1'b0, 1'b0, '0);
    vt[4]  = mkv(1'b0, 1'b0, '0,  '0,    1'b1, A10,   1'b0, 1'b0, 1'b0, '0);
    vt[5]  = mkv(1'b0, 1'b0, '0,  '0,    1'b1, A10,   1'b0, 1'b0, 1'b0, '0);
    vt[6]  = mkv(1'b0, 1'b0, '0,  '0,    1'b1, A10,   1'b0, 1'b1, 1'b0, '0);
    vt[7]  = mkv(1'b0, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b0, '0);
    vt[8]  = mkv(1'b0, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b1, D1);
    vt[9]  = mkv(1'b0, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b0, D1);
    vt[10] = mkv(1'b0, 1'b0, '0,  '0,    1'b1, A10,   1'b0, 1'b0, 1'b0, D1);
    vt[11] = mkv(1'b0, 1'b0, '0,  '0,    1'b1, A10,   1'b0, 1'b1, 1'b0, D1);
    vt[12] = mkv(1'b1, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b0, D1);
    vt[13] = mkv(1'b0, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b0, '0);
    vt[14] = mkv(1'b0, 1'b0, '0,  '0,    1'b0, '0,    1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < NV; i++) begin
      reset         = vt[i].rst;
      bus.wr_0_req  = vt[i].wr;
      bus.wr_0_addr = vt[i].wa;
      bus.wr_0_data = vt[i].wd;
      bus.rd_0_req  = vt[i].rd;
      bus.rd_0_addr = vt[i].ra;
      @(negedge clk);
      chk($sformatf("vec%0d wr_ack", i), WW'(bus.wr_0_ack), WW'(vt[i].e_wack));
      chk($sformatf("vec%0d rd_ack", i), WW'(bus.rd_0_ack), WW'(vt[i].e_rack));
      chk($sformatf("vec%0d rd_vld", i), WW'(bus.rd_0_vld), WW'(vt[i].e_vld));
      chk($sformatf("vec%0d rd_data", i), bus.rd_0_data, vt[i].e_dat);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle_bus(1);

    // Lone writer: one turnaround from reset direction, then 20 unbroken acks.
    for (int i = 0; i < 20; i++) begin
      wq_a.push_back(AW'(13'h0100 + i));
      wq_d.push_back({8'hA5, 32'(i), 32'h1234_0000 + 32'(i)});
    end
    run_streams("wr_burst", 60);
    first = -1; nack = 0; gaps = 0; nrd = 0;
    for (int c = 0; c < wr_tr.size(); c++) begin
      if (rd_tr[c]) nrd++;
      if (wr_tr[c]) begin
        if (first < 0) first = c;
        nack++;
      end else if (first >= 0 && nack < 20) begin
        gaps++;
      end
    end
    chk("wr_burst first_ack_cycle", WW'(first), WW'(2));
    chk("wr_burst ack_count", WW'(nack), WW'(20));
    chk("wr_burst gaps_after_first", WW'(gaps), WW'(0));
    chk("wr_burst rd_acks", WW'(nrd), WW'(0));

    // Preload 0..7 with i*3, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      wq_a.push_back(AW'(i));
      wq_d.push_back(WW'(i * 3));
    end
    run_streams("preload", 60);
    for (int i = 0; i < 8; i++) rq_a.push_back(AW'(i));
    run_streams("rd_seq", 60);
    chk("rd_seq count", WW'(got_d.size()), WW'(8));
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      chk($sformatf("rd_seq data%0d", i), got_d[i], WW'(i * 3));
    end
    run = 0; best = 0;
    for (int c = 0; c < rd_tr.size(); c++) begin
      run = rd_tr[c] ? run + 1 : 0;
      if (run > best) best = run;
    end
    chk("rd_seq consecutive_acks", WW'(best), WW'(8));

    // Top and bottom of the address space must not alias.
    wq_a.push_back(13'h1FFF); wq_d.push_back(DA);
    wq_a.push_back(13'h0000); wq_d.push_back(DB);
    rq_a.push_back(13'h1FFF);
    rq_a.push_back(13'h0000);
    run_streams("wrap", 60);
    if (got_d.size() == 2) begin
      chk("wrap data_1fff", got_d[0], DA);
      chk("wrap data_0000", got_d[1], DB);
    end else begin
      fail("wrap count", $sformatf("got %0d reads, expected 2", got_d.size()));
    end

    // Both sides saturated from reset: IDLE, TURN, then 4 wr / dead / 4 rd / dead.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wq_a.push_back(AW'(13'h0200 + i));
      wq_d.push_back({8'h3C, 32'(i * 7), 32'hBEEF_0000 + 32'(i)});
      rq_a.push_back(AW'(13'h0100 + i));
    end
    run_streams("arb", 80);
    perr = 0;
    for (int c = 0; c < wr_tr.size(); c++) begin
      ew = 1'b0;
      er = 1'b0;
      if (c >= 2 && c <= 30) begin
        k  = (c - 2) % 10;
        ew = (k < 4);
        er = (k >= 5 && k <= 8);
      end
      if (wr_tr[c] != ew || rd_tr[c] != er) perr++;
    end
    chk("arb pattern_errors", WW'(perr), WW'(0));
    chk("arb trace_cycles", WW'(wr_tr.size()), WW'(33));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
